// File: rtl/fd_avalon_burst_mem_responder.sv
// Avalon-MM word-RAM responder: burst reads for the read master, single-word
// writes for the write master, with optional periodic write backpressure.
module fd_avalon_burst_mem_responder #(
    parameter int ADDR_W          = 12,
    parameter int WM_STALL_PERIOD = 0
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iRM_read,
    input  logic [31:0] iRM_read_address,
    input  logic [9:0]  iRM_burst_length,
    output logic        oRM_wait_request,
    output logic        oRM_read_data_valid,
    output logic [31:0] oRM_read_data,
    input  logic        iWM_write,
    input  logic [31:0] iWM_write_address,
    input  logic [31:0] iWM_write_data,
    output logic        oWM_wait_request,
    output logic        oBusy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_idx, w_idx_nxt;
    logic [9:0]        r_cnt, w_cnt_nxt;
    logic              w_issue;

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [31:0]       r_rdata;
    logic              r_rvalid;

    logic              w_wm_wait;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_idx;
    logic              w_unused_bits;

    // r_cnt holds reads still to issue; BURST lingers one extra cycle with
    // r_cnt==0 so the last word is presented before wait_request drops.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_issue     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (iRM_read) begin
                    w_idx_nxt   = iRM_read_address[ADDR_W+1:2];
                    w_cnt_nxt   = (iRM_burst_length == 10'd0) ? 10'd1 : iRM_burst_length;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (r_cnt != 10'd0) begin
                    w_issue   = 1'b1;
                    w_idx_nxt = r_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_cnt_nxt = r_cnt - 10'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rvalid <= w_issue;
            if (w_issue)
                r_rdata <= r_mem[r_idx];
        end
    end

    assign w_wr_idx = iWM_write_address[ADDR_W+1:2];
    assign w_wr_en  = iWM_write && !w_wm_wait;

    // Non-blocking write against the registered read above gives read-first on collisions.
    always_ff @(posedge iClk) begin
        if (w_wr_en)
            r_mem[w_wr_idx] <= iWM_write_data;
    end

    generate
        if (WM_STALL_PERIOD > 1) begin : g_stall
            localparam int CW = $clog2(WM_STALL_PERIOD);
            localparam logic [CW-1:0] LAST = CW'(WM_STALL_PERIOD - 1);
            logic [CW-1:0] r_stall_cnt;
            always_ff @(posedge iClk) begin
                if (iReset)
                    r_stall_cnt <= '0;
                else if (r_stall_cnt == LAST)
                    r_stall_cnt <= '0;
                else
                    r_stall_cnt <= r_stall_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
            assign w_wm_wait = (r_stall_cnt == LAST);
        end else if (WM_STALL_PERIOD == 1) begin : g_stall_always
            assign w_wm_wait = 1'b1;
        end else begin : g_no_stall
            assign w_wm_wait = 1'b0;
        end
    endgenerate

    assign w_unused_bits = ^{iRM_read_address[31:ADDR_W+2], iRM_read_address[1:0],
                             iWM_write_address[31:ADDR_W+2], iWM_write_address[1:0]};

    assign oRM_wait_request    = (r_state == S_BURST);
    assign oBusy               = (r_state == S_BURST);
    assign oRM_read_data_valid = r_rvalid;
    assign oRM_read_data       = r_rdata;
    assign oWM_wait_request    = w_wm_wait;

endmodule

// File: doc/fd_avalon_burst_mem_responder.md
Name: fd_avalon_burst_mem_responder

Overview:
- Avalon-MM memory responder that serves the face-detection core's read master (burst reads) and write master (single-word writes).
- Backed by on-chip 32-bit word RAM. Used as the simulation and on-chip frame/result buffer in place of SDRAM.
- Write-side backpressure is programmable, so master-side wait handling can be exercised.

Parameters:
- ADDR_W, 12, word-address width; RAM depth = 2^ADDR_W words.
- WM_STALL_PERIOD, 0, write wait-request injected 1 cycle in every WM_STALL_PERIOD cycles; 0 = never stall.

Ports:
- iClk  in  1  system clock, all logic rising-edge.
- iReset  in  1  synchronous, active-high reset.
- iRM_read  in  1  burst read request.
- iRM_read_address  in  32  byte address of first word; bits [1:0] ignored.
- iRM_burst_length  in  10  words in burst; 0 treated as 1.
- oRM_wait_request  out  1  read request not accepted / burst in progress.
- oRM_read_data_valid  out  1  oRM_read_data carries a burst word.
- oRM_read_data  out  32  read word.
- iWM_write  in  1  write request.
- iWM_write_address  in  32  byte address; bits [1:0] ignored.
- iWM_write_data  in  32  write word.
- oWM_wait_request  out  1  write not accepted this cycle.
- oBusy  out  1  read FSM not in IDLE.

Behaviour:
- Reset (iReset=1 at an edge), all outputs 0 on the following cycle:
  - oRM_wait_request, oRM_read_data_valid, oRM_read_data, oWM_wait_request, oBusy.
  - Read FSM returns to IDLE; stall counter cleared.
  - RAM contents are not cleared.
- Word index = address[ADDR_W+1:2]. Upper address bits are dropped, so any address aliases into RAM.
- Read FSM states: IDLE, BURST.
  - IDLE: oRM_wait_request=0. A request is accepted when iRM_read=1 at an edge (cycle T).
  - On acceptance, latch start index and length (len = max(iRM_burst_length,1)), then enter BURST.
  - BURST: oRM_wait_request=1 and oBusy=1 from T+1.
  - One RAM read is issued per cycle for len cycles. The index increments by 1 and wraps modulo 2^ADDR_W.
  - RAM has 1-cycle registered latency. oRM_read_data_valid=1 on cycles T+2 .. T+1+len, contiguous with no gaps. No read-side backpressure exists.
  - The FSM returns to IDLE so that oRM_wait_request=0 and oBusy=0 at cycle T+2+len. A new read may be accepted at that edge.
  - oRM_read_data holds its last value when valid=0.
  - iRM_read while oRM_wait_request=1 is ignored; the master must hold the request.
- Write path:
  - A write is accepted at an edge where iWM_write=1 and oWM_wait_request=0. The word is stored at that edge.
  - A write with oWM_wait_request=1 is not stored; the master holds it.
- Stall generation (WM_STALL_PERIOD=N>0):
  - A free-running counter counts 0..N-1 and wraps.
  - oWM_wait_request=1 exactly in cycles where the counter equals N-1. The cycle after reset has counter=0.
  - N=1 means permanently stalled. This is legal; the bench must avoid it.
- Read and write are independent and may proceed in the same cycle.
  - If the same word is written and read in one cycle, the read returns the old data (read-first).
- Reset mid-burst: valid drops to 0 on the next cycle and the remaining words are discarded.
- Burst length range 1..1023. A value of 0 is treated as 1. Length is not checked against RAM depth; reads wrap.

Test Plan:
- Write-then-burst: writes of 0x1000_0000+i to byte addr 0x100+4i for i=0..7, then read addr 0x100 len 8 at cycle T -> valid T+2..T+9 with data 0x1000_0000..0x1000_0007; wait_request high T+1..T+9, low T+10.
- Wrap-around, ADDR_W=4: words 14,15,0,1 preloaded with A,B,C,D; read addr 0x38 len 4 -> A,B,C,D.
- Zero/edge lengths: len=0 -> exactly 1 valid word; len=1023 -> 1023 contiguous valids; request during BURST is ignored, no extra valids.
- Write backpressure, WM_STALL_PERIOD=3: continuous write requests for 9 cycles -> wait_request high on cycles 2,5,8 after reset; only writes on the other 6 cycles stored (read back to verify).
- Collision: write 0xDEAD_BEEF to word 5 (old value 0x5) in the same cycle the burst reads word 5 -> returned 0x5; a subsequent read returns 0xDEAD_BEEF.
- Reset mid-burst: assert iReset at 3rd valid of len 8 burst -> valid 0 and wait_request 0 next cycle; a new read accepted immediately returns correct data.
